// File: rtl/multiplier_32.sv
// rtl/multiplier_32.sv - 32x32 radix-16 sequential multiplier, signed/unsigned operands, 64-bit product
module multiplier_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        a_signed,
  input  logic        b_signed,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        rdy,
  output logic [63:0] mul_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg;
  logic [63:0] acc;

  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [3:0]  digit;
  logic [35:0] prod;
  logic [63:0] partial;

  // Operand magnitudes and the current shifted partial product.
  // 0x80000000 negates to itself, which read as unsigned is the correct 2^31.
  always_comb begin
    neg_a   = a_signed & multiplicand[31];
    neg_b   = b_signed & multiplier[31];
    abs_a   = neg_a ? (32'd0 - multiplicand) : multiplicand;
    abs_b   = neg_b ? (32'd0 - multiplier) : multiplier;
    digit   = mag_b[{cnt, 2'b00} +: 4];
    prod    = {4'd0, mag_a} * {32'd0, digit};
    partial = {28'd0, prod} << {cnt, 2'b00};
  end

  // Busy covers the whole operation, including the final sign-fixup cycle.
  assign busy = (state != IDLE);

  // Control FSM with accumulator; dropping start mid-operation abandons it silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      mag_a   <= 32'd0;
      mag_b   <= 32'd0;
      neg     <= 1'b0;
      acc     <= 64'd0;
      rdy     <= 1'b0;
      mul_out <= 64'd0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg   <= neg_a ^ neg_b;
            acc   <= 64'd0;
            cnt   <= 3'd0;
            state <= CALC;
          end
        end
        CALC: begin
          if (!start) begin
            cnt   <= 3'd0;
            state <= IDLE;
          end else begin
            acc <= acc + partial;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            mul_out <= neg ? (64'd0 - acc) : acc;
            rdy     <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_32.sv
// tb/tb_multiplier_32.sv - scoreboard testbench for multiplier_32
module tb_multiplier_32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        a_signed = 1'b0;
  logic        b_signed = 1'b0;
  logic [31:0] multiplicand = 32'd0;
  logic [31:0] multiplier = 32'd0;
  logic        busy;
  logic        rdy;
  logic [63:0] mul_out;

  multiplier_32 dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a_signed     (a_signed),
    .b_signed     (b_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .rdy          (rdy),
    .mul_out      (mul_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          cap;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] last_want = 64'd0;
  logic last_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] model(input logic as, input logic bs,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = as ? {{32{a[31]}}, a} : {32'd0, a};
    eb = bs ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Scoreboard consumer: every rdy pops one expected product and its capture cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (last_rdy) check("rdy_single_cycle", 64'(rdy), 64'd0);
    if (rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("mul_out", mul_out, e.prod);
        check("latency", 64'(cyc - e.cap), 64'd9);
      end
    end
    last_rdy <= rdy;
  end

  // Starts an op at the current negedge, scrambles operands after capture, waits for rdy.
  task automatic do_op(input logic as, input logic bs, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] want, output int rdy_cyc);
    exp_t e;
    start        = 1'b1;
    a_signed     = as;
    b_signed     = bs;
    multiplicand = a;
    multiplier   = b;
    e.prod = want;
    e.cap  = cyc + 1;
    sb.push_back(e);
    last_want = want;
    @(negedge clk);
    check("busy_in_calc", 64'(busy), 64'd1);
    a_signed     = 1'($urandom);
    b_signed     = 1'($urandom);
    multiplicand = $urandom;
    multiplier   = $urandom;
    rdy_cyc = -1;
    for (int i = 0; i < 20 && rdy_cyc < 0; i++) begin
      if (rdy) rdy_cyc = cyc;
      else @(negedge clk);
    end
    if (rdy_cyc < 0) check("rdy_timeout", 64'd0, 64'd1);
  endtask

  task automatic single_op(input logic as, input logic bs, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] want);
    int r;
    do_op(as, bs, a, b, want, r);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int r1;
    int r2;
    logic        ra;
    logic        rb;
    logic [31:0] xa;
    logic [31:0] xb;

    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rdy", 64'(rdy), 64'd0);
    check("reset_mul_out", mul_out, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    single_op(1'b0, 1'b0, 32'd7, 32'd6, 64'h000000000000002A);
    single_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    single_op(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFFFFFFFFFF);
    single_op(1'b1, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    single_op(1'b1, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 64'hFFFFFFFE00000002);
    single_op(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000);
    single_op(1'b1, 1'b1, 32'h80000000, 32'h00000003, 64'hFFFFFFFE80000000);

    // Abort after E4: no rdy, result held, busy drops.
    start        = 1'b1;
    a_signed     = 1'b0;
    b_signed     = 1'b0;
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    repeat (5) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_after", 64'(busy), 64'd0);
    check("abort_rdy", 64'(rdy), 64'd0);
    check("abort_mul_out_held", mul_out, last_want);
    repeat (12) @(negedge clk);
    single_op(1'b0, 1'b1, 32'd100, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFF9C);

    // Asynchronous reset in the middle of an operation.
    start        = 1'b1;
    a_signed     = 1'b0;
    b_signed     = 1'b0;
    multiplicand = 32'h00001234;
    multiplier   = 32'h00005678;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_rdy", 64'(rdy), 64'd0);
    check("areset_mul_out", mul_out, 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    single_op(1'b0, 1'b0, 32'h00001234, 32'h00005678, 64'h0000000006260060);

    // Back-to-back with start held.
    do_op(1'b0, 1'b0, 32'd3, 32'd5, 64'h000000000000000F, r1);
    do_op(1'b1, 1'b1, 32'd0, 32'h12345678, 64'h0, r2);
    start = 1'b0;
    check("b2b_spacing", 64'(r2 - r1), 64'd10);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      ra = 1'($urandom);
      rb = 1'($urandom);
      xa = $urandom;
      xb = $urandom;
      if (i == 0) xa = 32'h80000000;
      single_op(ra, rb, xa, xb, model(ra, rb, xa, xb));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
